// File: rtl/common_pkg.sv
// Constants, the shared credit flit layout and the round-robin helper used by
// the credit link endpoints and the switch arbiters.
package common_pkg;

    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_D_W           = 8;
    localparam int DEFAULT_A_W           = 4;
    localparam int DEFAULT_VC_FIFO_DEPTH = 4;
    localparam int MAX_VC                = 16;

    typedef struct packed {
        logic                   last;
        logic [DEFAULT_A_W-1:0] addr;
        logic [DEFAULT_D_W-1:0] data;
    } credit_flit_t;

    // One-hot grant of the first requester after ptr, wrapping at n-1.
    function automatic logic [MAX_VC-1:0] rr_next(
        input int unsigned       ptr,
        input logic [MAX_VC-1:0] req,
        input int unsigned       n = MAX_VC
    );
        logic [MAX_VC-1:0] gnt;
        logic              found;
        int unsigned       idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_VC; i++) begin
            if (i < n) begin
                idx = ptr + 1 + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/noc_if.sv
// Credit-based link between a transmitter and a receiver: one flit register
// with a one-hot VC target, and per-VC credit returns flowing back.
interface noc_if #(
    parameter int VC_W = common_pkg::DEFAULT_VC_W,
    parameter int D_W  = common_pkg::DEFAULT_D_W,
    parameter int A_W  = common_pkg::DEFAULT_A_W
) ();

    logic [A_W+D_W:0] credit_packet;
    logic [VC_W-1:0]  credit_vc_target;
    logic [VC_W-1:0]  credit_vc_credit_gnt;

    modport transmitter (
        output credit_packet,
        output credit_vc_target,
        input  credit_vc_credit_gnt
    );

    modport receiver (
        input  credit_packet,
        input  credit_vc_target,
        output credit_vc_credit_gnt
    );

endinterface

// File: rtl/credit_vc_counter.sv
// Per-VC credit counter: starts full, +1 per returned credit, -1 per sent flit,
// saturating at full so a stray credit return cannot wrap it.
module credit_vc_counter
    import common_pkg::*;
#(
    parameter int DEPTH = DEFAULT_VC_FIFO_DEPTH,
    localparam int CW   = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic nonzero
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= FULL;
        end else if (inc && !dec) begin
            if (count != FULL) begin
                count <= count + CW'(1);
            end
        end else if (dec && !inc) begin
            if (count != '0) begin
                count <= count - CW'(1);
            end
        end
    end

    assign nonzero = (count != '0);

    // A credit return with nothing in flight means the receiver lost track.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst) !(inc && !dec && count == FULL)
    ) else $error("credit_vc_counter: credit returned while counter is full");

endmodule

// File: rtl/credit_bp_tx.sv
// Transmit-side credit manager: arbitrates DVR sources that hold credit and
// registers the winning flit onto the credit link.
module credit_bp_tx
    import common_pkg::*;
#(
    parameter int VC_W        = DEFAULT_VC_W,
    parameter int D_W         = DEFAULT_D_W,
    parameter int A_W         = DEFAULT_A_W,
    parameter int DEPTH       = DEFAULT_VC_FIFO_DEPTH,
    parameter int FAIR_VC_ARB = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [VC_W-1:0]             i_v,
    input  logic [VC_W-1:0][A_W+D_W:0]  i_d,
    output logic [VC_W-1:0]             o_b,
    noc_if.transmitter                  to_rx
);

    localparam int F_W   = A_W + D_W + 1;
    localparam int IDX_W = (VC_W > 1) ? $clog2(VC_W) : 1;

    logic [VC_W-1:0]  nonzero;
    logic [VC_W-1:0]  elig;
    logic [VC_W-1:0]  sel;
    logic [VC_W-1:0]  xfer;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic [F_W-1:0]   pkt;
    logic [VC_W-1:0]  tgt;

    for (genvar v = 0; v < VC_W; v++) begin : g_vc
        credit_vc_counter #(
            .DEPTH (DEPTH)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (to_rx.credit_vc_credit_gnt[v]),
            .dec     (xfer[v]),
            .nonzero (nonzero[v])
        );

        // A stalled source must present the same flit until it is taken.
        a_src_stable: assert property (
            @(posedge clk) (rst && i_v[v] && o_b[v]) |=> (i_d[v] == $past(i_d[v]))
        ) else $error("credit_bp_tx: i_d changed while held off");
    end

    // Credit is the registered count only; a same-cycle return does not help.
    assign elig = i_v & nonzero;

    always_comb begin
        sel = '0;
        if (FAIR_VC_ARB != 0) begin
            sel = VC_W'(rr_next(32'(ptr), MAX_VC'(elig), VC_W));
        end else begin
            sel = elig & (~elig + VC_W'(1));
        end
    end

    always_comb begin
        win_idx = '0;
        for (int v = 0; v < VC_W; v++) begin
            if (sel[v]) begin
                win_idx = IDX_W'(v);
            end
        end
    end

    assign o_b  = rst ? ~sel : '1;
    assign xfer = i_v & ~o_b;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tgt <= '0;
            pkt <= '0;
            ptr <= IDX_W'(VC_W - 1);
        end else begin
            tgt <= xfer;
            if (|xfer) begin
                pkt <= i_d[win_idx];
                ptr <= win_idx;
            end
        end
    end

    assign to_rx.credit_packet    = pkt;
    assign to_rx.credit_vc_target = tgt;

endmodule

// File: tb/tb_credit_bp_tx.sv
// Bench for credit_bp_tx: a static-priority and a round-robin instance side by
// side, driven by a vector table, a payload sequence and a randomized phase.
module tb_credit_bp_tx;
    import common_pkg::*;

    localparam int VC   = 2;
    localparam int DEP  = 4;
    localparam int FULL = DEP - 1;
    localparam int FW   = DEFAULT_A_W + DEFAULT_D_W + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [1:0]           iv  [2];
    logic [1:0][FW-1:0]   id  [2];
    logic [1:0]           gnt [2];
    logic [1:0]           ob  [2];
    logic [1:0]           tgt [2];
    logic [FW-1:0]        pkt [2];
    logic [1:0]           cr  [2][2];

    noc_if #(.VC_W(VC), .D_W(DEFAULT_D_W), .A_W(DEFAULT_A_W)) nif_s ();
    noc_if #(.VC_W(VC), .D_W(DEFAULT_D_W), .A_W(DEFAULT_A_W)) nif_r ();

    assign nif_s.credit_vc_credit_gnt = gnt[0];
    assign nif_r.credit_vc_credit_gnt = gnt[1];
    assign tgt[0] = nif_s.credit_vc_target;
    assign tgt[1] = nif_r.credit_vc_target;
    assign pkt[0] = nif_s.credit_packet;
    assign pkt[1] = nif_r.credit_packet;
    assign cr[0][0] = dut_s.g_vc[0].u_cnt.count;
    assign cr[0][1] = dut_s.g_vc[1].u_cnt.count;
    assign cr[1][0] = dut_r.g_vc[0].u_cnt.count;
    assign cr[1][1] = dut_r.g_vc[1].u_cnt.count;

    credit_bp_tx #(
        .VC_W(VC), .D_W(DEFAULT_D_W), .A_W(DEFAULT_A_W), .DEPTH(DEP), .FAIR_VC_ARB(0)
    ) dut_s (
        .clk(clk), .rst(rst), .i_v(iv[0]), .i_d(id[0]), .o_b(ob[0]), .to_rx(nif_s)
    );

    credit_bp_tx #(
        .VC_W(VC), .D_W(DEFAULT_D_W), .A_W(DEFAULT_A_W), .DEPTH(DEP), .FAIR_VC_ARB(1)
    ) dut_r (
        .clk(clk), .rst(rst), .i_v(iv[1]), .i_d(id[1]), .o_b(ob[1]), .to_rx(nif_r)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] iv;
        logic [1:0] gnt;
        logic [1:0] ob_s;
        logic [1:0] ob_r;
        logic [1:0] tgt_s;
        logic [1:0] tgt_r;
        int         cs0, cs1, cr0, cr1;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic r, input logic [1:0] v, input logic [1:0] g,
                       input logic [1:0] obs, input logic [1:0] obr,
                       input logic [1:0] ts, input logic [1:0] tr,
                       input int a, input int b, input int c, input int d);
        vec_t e;
        e.rst = r; e.iv = v; e.gnt = g; e.ob_s = obs; e.ob_r = obr;
        e.tgt_s = ts; e.tgt_r = tr; e.cs0 = a; e.cs1 = b; e.cr0 = c; e.cr1 = d;
        tbl.push_back(e);
    endtask

    // Reference: credits as integers, winner chosen by rule over the eligible set.
    int         m_cred [2][2];
    int         m_last [2];
    logic       src_v  [2][2];
    logic [FW-1:0] src_d [2][2];

    function automatic int pick(input logic [1:0] elig, input bit fair, input int last);
        if (!fair) begin
            for (int v = 0; v < VC; v++) if (elig[v]) return v;
        end else begin
            for (int k = 1; k <= VC; k++) begin
                int v;
                v = (last + k) % VC;
                if (elig[v]) return v;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_last[d] = VC - 1;
            for (int v = 0; v < VC; v++) m_cred[d][v] = FULL;
        end
    endtask

    logic [FW-1:0]  flit0, flit1;
    credit_flit_t   f;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        flit0 = {1'b0, 4'h1, 8'h11};
        flit1 = {1'b1, 4'h2, 8'h22};
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 2'b00; gnt[d] = 2'b00;
            id[d][0] = flit0; id[d][1] = flit1;
        end

        //   rst iv     gnt    ob_s   ob_r   tgt_s  tgt_r  cs0 cs1 cr0 cr1
        add(1, 2'b01, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2, 3, 2, 3);
        add(1, 2'b01, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 1, 3, 1, 3);
        add(1, 2'b01, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 0, 3, 0, 3);
        add(1, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 0, 3, 0, 3);
        add(1, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 1, 3, 1, 3);
        add(1, 2'b01, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 0, 3, 0, 3);
        add(1, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 0, 3, 0, 3);
        add(1, 2'b00, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 1, 3, 1, 3);
        for (int i = 0; i < 4; i++)
            add(1, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 1, 3, 1, 3);
        add(1, 2'b00, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2, 3, 2, 3);
        add(1, 2'b00, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 3, 3, 3, 3);
        add(0, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 3, 3, 3, 3);
        add(1, 2'b11, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2, 3, 2, 3);
        add(1, 2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10, 1, 3, 2, 2);
        add(1, 2'b11, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 0, 3, 1, 2);
        add(1, 2'b11, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 0, 2, 1, 1);
        add(1, 2'b11, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 0, 1, 0, 1);
        add(1, 2'b11, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 0, 0, 0, 0);
        add(1, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0);
        add(1, 2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 1, 0, 1, 0);
        add(0, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 3, 3, 3, 3);
        add(1, 2'b11, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2, 3, 2, 3);
        add(1, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2, 3, 2, 3);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ob", 32'(ob[d]), 32'h3);
            chk("reset_tgt", 32'(tgt[d]), 32'h0);
            chk("reset_pkt", 32'(pkt[d]), 32'h0);
            for (int v = 0; v < VC; v++) chk("reset_cred", 32'(cr[d][v]), 32'(FULL));
        end

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            for (int d = 0; d < 2; d++) begin
                iv[d] = tbl[i].iv; gnt[d] = tbl[i].gnt;
            end
            @(negedge clk);
            chk($sformatf("tbl%0d_ob_s", i), 32'(ob[0]), 32'(tbl[i].ob_s));
            chk($sformatf("tbl%0d_ob_r", i), 32'(ob[1]), 32'(tbl[i].ob_r));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_tgt_s", i), 32'(tgt[0]), 32'(tbl[i].tgt_s));
            chk($sformatf("tbl%0d_tgt_r", i), 32'(tgt[1]), 32'(tbl[i].tgt_r));
            chk($sformatf("tbl%0d_cs0", i), 32'(cr[0][0]), 32'(tbl[i].cs0));
            chk($sformatf("tbl%0d_cs1", i), 32'(cr[0][1]), 32'(tbl[i].cs1));
            chk($sformatf("tbl%0d_cr0", i), 32'(cr[1][0]), 32'(tbl[i].cr0));
            chk($sformatf("tbl%0d_cr1", i), 32'(cr[1][1]), 32'(tbl[i].cr1));
            if (tbl[i].tgt_s != 2'b00)
                chk($sformatf("tbl%0d_pkt_s", i), 32'(pkt[0]),
                    32'((tbl[i].tgt_s == 2'b01) ? flit0 : flit1));
        end
        gnt[0] = 2'b00;
        gnt[1] = 2'b00;

        // Payload integrity on VC1.
        for (int d = 0; d < 2; d++) begin
            id[d][1] = {1'b1, 4'h3, 8'hA5};
            iv[d]    = 2'b10;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("payload_ob", 32'(ob[d]), 32'h1);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 2'b00;
            f = credit_flit_t'(pkt[d]);
            chk("payload_tgt", 32'(tgt[d]), 32'h2);
            chk("payload_last", 32'(f.last), 32'h1);
            chk("payload_addr", 32'(f.addr), 32'h3);
            chk("payload_data", 32'(f.data), 32'hA5);
        end

        // Randomized phase against the reference model.
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        for (int d = 0; d < 2; d++)
            for (int v = 0; v < VC; v++) src_v[d][v] = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            int        win [2];
            logic [1:0] elig;
            logic [1:0] exp_ob;
            rst = ($urandom_range(0, 199) != 0);
            for (int d = 0; d < 2; d++) begin
                for (int v = 0; v < VC; v++) begin
                    if (!src_v[d][v] && $urandom_range(0, 2) != 0) begin
                        src_v[d][v] = 1'b1;
                        src_d[d][v] = FW'($urandom);
                    end
                    gnt[d][v] = (m_cred[d][v] < FULL) && ($urandom_range(0, 3) == 0);
                    iv[d][v]  = src_v[d][v];
                    id[d][v]  = src_d[d][v];
                end
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int v = 0; v < VC; v++) elig[v] = src_v[d][v] && (m_cred[d][v] > 0);
                win[d] = rst ? pick(elig, d == 1, m_last[d]) : -1;
                exp_ob = 2'b11;
                if (win[d] >= 0) exp_ob[win[d]] = 1'b0;
                chk($sformatf("rnd_ob%0d", d), 32'(ob[d]), 32'(exp_ob));
            end
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (!rst) begin
                    m_last[d] = VC - 1;
                    for (int v = 0; v < VC; v++) m_cred[d][v] = FULL;
                    chk($sformatf("rnd_rst_tgt%0d", d), 32'(tgt[d]), 32'h0);
                    chk($sformatf("rnd_rst_pkt%0d", d), 32'(pkt[d]), 32'h0);
                end else begin
                    for (int v = 0; v < VC; v++) begin
                        m_cred[d][v] += int'(gnt[d][v]) - ((win[d] == v) ? 1 : 0);
                        if (m_cred[d][v] > FULL) m_cred[d][v] = FULL;
                    end
                    if (win[d] >= 0) begin
                        chk($sformatf("rnd_tgt%0d", d), 32'(tgt[d]), 32'(1 << win[d]));
                        chk($sformatf("rnd_pkt%0d", d), 32'(pkt[d]), 32'(src_d[d][win[d]]));
                        src_v[d][win[d]] = 1'b0;
                        m_last[d] = win[d];
                    end else begin
                        chk($sformatf("rnd_tgt%0d", d), 32'(tgt[d]), 32'h0);
                    end
                end
                for (int v = 0; v < VC; v++)
                    chk($sformatf("rnd_cred%0d_%0d", d, v), 32'(cr[d][v]), 32'(m_cred[d][v]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
